// File: rtl/ec_acc_pkg.sv
// Shared constants, FSM encoding and sizing helpers for the EC accelerator egress path.
package ec_acc_pkg;

  localparam int unsigned DEF_BM_MULT_UNIT_NUM = 2;
  localparam int unsigned DEF_W                = 4;
  localparam int unsigned DEF_PACKET_LENGTH    = 8;
  localparam int unsigned DEF_OUTBUF_DATA_W    = 16;
  localparam int unsigned DEF_OUTBUF_DEPTH     = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_SEND  = 2'd2
  } outbuf_state_e;

  function automatic int unsigned calc_word_w(input int unsigned units,
                                              input int unsigned w,
                                              input int unsigned plen);
    return units * w * plen;
  endfunction

  function automatic int unsigned calc_beats(input int unsigned word_w,
                                             input int unsigned bus_w);
    return word_w / bus_w;
  endfunction

  localparam int unsigned DEF_WORD_W = calc_word_w(DEF_BM_MULT_UNIT_NUM, DEF_W, DEF_PACKET_LENGTH);
  localparam int unsigned DEF_BEATS  = calc_beats(DEF_WORD_W, DEF_OUTBUF_DATA_W);

endpackage

// File: rtl/outbuf_fifo_mem.sv
// Word FIFO: SRAM array with wrapping pointers, registered one-cycle read data,
// and registered occupancy/full/empty flags.
module outbuf_fifo_mem
  import ec_acc_pkg::*;
#(
  parameter  int unsigned DATA_W = DEF_WORD_W,
  parameter  int unsigned DEPTH  = DEF_OUTBUF_DEPTH,
  localparam int unsigned PTR_W  = $clog2(DEPTH),
  localparam int unsigned CNT_W  = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_wr_en,
  input  logic [DATA_W-1:0] i_wr_data,
  input  logic              i_rd_en,
  output logic [DATA_W-1:0] o_rd_data,
  output logic [CNT_W-1:0]  o_count,
  output logic              o_full,
  output logic              o_empty,
  output logic              o_empty_nxt_c
);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [CNT_W-1:0]  r_count;
  logic              r_full;
  logic              r_empty;
  logic [DATA_W-1:0] r_rd_data;

  logic              w_wr_acc;
  logic              w_rd_acc;
  logic [CNT_W-1:0]  w_count_nxt;

  // Full/empty come from the pre-cycle count, so a write into a full FIFO is
  // dropped even when a read frees a slot on the same edge.
  always_comb begin
    w_wr_acc    = i_wr_en & ~r_full;
    w_rd_acc    = i_rd_en & ~r_empty;
    w_count_nxt = r_count + CNT_W'(w_wr_acc) - CNT_W'(w_rd_acc);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_count   <= '0;
      r_full    <= 1'b0;
      r_empty   <= 1'b1;
      r_rd_data <= '0;
    end else begin
      if (w_wr_acc) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_rd_acc) begin
        r_rd_ptr  <= r_rd_ptr + PTR_W'(1);
        r_rd_data <= r_mem[r_rd_ptr];
      end
      r_count <= w_count_nxt;
      r_full  <= (w_count_nxt == CNT_W'(DEPTH));
      r_empty <= (w_count_nxt == '0);
    end
  end

  // Storage array carries no reset; pointers define what is live.
  always_ff @(posedge clk) begin
    if (!rst && w_wr_acc) r_mem[r_wr_ptr] <= i_wr_data;
  end

  assign o_rd_data     = r_rd_data;
  assign o_count       = r_count;
  assign o_full        = r_full;
  assign o_empty       = r_empty;
  assign o_empty_nxt_c = (w_count_nxt == '0);

endmodule

// File: rtl/output_buffer.sv
// Egress buffer: queues parity words and serializes each onto a valid/ready bus, LSB beat first.
// Optional sticky overflow flag output enabled by defining OUTBUF_OVERFLOW_FLAG_EN.
module output_buffer
  import ec_acc_pkg::*;
#(
  parameter  int unsigned BM_MULT_UNIT_NUM = DEF_BM_MULT_UNIT_NUM,
  parameter  int unsigned W                = DEF_W,
  parameter  int unsigned PACKET_LENGTH    = DEF_PACKET_LENGTH,
  parameter  int unsigned OUTBUF_DATA_W    = DEF_OUTBUF_DATA_W,
  parameter  int unsigned OUTBUF_DEPTH     = DEF_OUTBUF_DEPTH,
  localparam int unsigned WORD_W           = calc_word_w(BM_MULT_UNIT_NUM, W, PACKET_LENGTH),
  localparam int unsigned BEATS            = calc_beats(WORD_W, OUTBUF_DATA_W),
  localparam int unsigned CNT_W            = $clog2(OUTBUF_DEPTH + 1)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     cntl_outbuf_wr_req,
  input  logic [WORD_W-1:0]        cntl_outbuf_wr_data,
  output logic                     outbuf_cntl_full,
  output logic                     outbuf_cntl_idle,
  output logic [CNT_W-1:0]         outbuf_cntl_count,
  output logic                     outbuf_tx_valid,
  output logic [OUTBUF_DATA_W-1:0] outbuf_tx_data,
  output logic                     outbuf_tx_last,
`ifdef OUTBUF_OVERFLOW_FLAG_EN
  output logic                     outbuf_cntl_ovf,
`endif
  input  logic                     tx_outbuf_ready
);

  localparam int unsigned BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;

  logic [WORD_W-1:0]                   w_rd_data;
  logic [CNT_W-1:0]                    w_count;
  logic                                w_full;
  logic                                w_empty;
  logic                                w_empty_nxt;
  logic                                w_rd_en;
  logic                                w_hs;
  logic                                w_last_hs;
  logic [BEAT_W-1:0]                   w_beat_nxt;

  outbuf_state_e                       r_state;
  logic [BEATS-1:0][OUTBUF_DATA_W-1:0] r_hold;
  logic [BEAT_W-1:0]                   r_beat_idx;
  logic                                r_tx_valid;
  logic [OUTBUF_DATA_W-1:0]            r_tx_data;
  logic                                r_tx_last;
  logic                                r_idle;

  outbuf_fifo_mem #(
    .DATA_W (WORD_W),
    .DEPTH  (OUTBUF_DEPTH)
  ) u_fifo (
    .clk           (clk),
    .rst           (rst),
    .i_wr_en       (cntl_outbuf_wr_req),
    .i_wr_data     (cntl_outbuf_wr_data),
    .i_rd_en       (w_rd_en),
    .o_rd_data     (w_rd_data),
    .o_count       (w_count),
    .o_full        (w_full),
    .o_empty       (w_empty),
    .o_empty_nxt_c (w_empty_nxt)
  );

  // A read is issued from IDLE, or back-to-back on the final beat's handshake.
  always_comb begin
    w_hs       = r_tx_valid & tx_outbuf_ready;
    w_last_hs  = (r_state == ST_SEND) & w_hs & r_tx_last;
    w_rd_en    = ~w_empty & ((r_state == ST_IDLE) | w_last_hs);
    w_beat_nxt = r_beat_idx + BEAT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_hold     <= '0;
      r_beat_idx <= '0;
      r_tx_valid <= 1'b0;
      r_tx_data  <= '0;
      r_tx_last  <= 1'b0;
      r_idle     <= 1'b1;
    end else begin
      unique case (r_state)
        ST_IDLE: begin
          if (w_rd_en) r_state <= ST_FETCH;
        end
        ST_FETCH: begin
          r_hold     <= w_rd_data;
          r_beat_idx <= '0;
          r_tx_valid <= 1'b1;
          r_tx_data  <= w_rd_data[OUTBUF_DATA_W-1:0];
          r_tx_last  <= (BEATS == 1);
          r_state    <= ST_SEND;
        end
        ST_SEND: begin
          if (w_hs) begin
            if (r_tx_last) begin
              r_tx_valid <= 1'b0;
              r_tx_last  <= 1'b0;
              r_state    <= w_rd_en ? ST_FETCH : ST_IDLE;
            end else begin
              r_beat_idx <= w_beat_nxt;
              r_tx_data  <= r_hold[w_beat_nxt];
              r_tx_last  <= (w_beat_nxt == BEAT_W'(BEATS - 1));
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase
      // Idle next cycle only if the FIFO drains and the FSM lands in IDLE.
      r_idle <= w_empty_nxt & ~w_rd_en & ((r_state == ST_IDLE) | w_last_hs);
    end
  end

`ifdef OUTBUF_OVERFLOW_FLAG_EN
  logic w_wr_drop;
  logic r_ovf;

  assign w_wr_drop = cntl_outbuf_wr_req & w_full;

  always_ff @(posedge clk) begin
    if (rst)            r_ovf <= 1'b0;
    else if (w_wr_drop) r_ovf <= 1'b1;
  end

  assign outbuf_cntl_ovf = r_ovf;
`endif

  assign outbuf_cntl_full  = w_full;
  assign outbuf_cntl_idle  = r_idle;
  assign outbuf_cntl_count = w_count;
  assign outbuf_tx_valid   = r_tx_valid;
  assign outbuf_tx_data    = r_tx_data;
  assign outbuf_tx_last    = r_tx_last;

endmodule

// File: tb/tb_output_buffer.sv
// Bench for output_buffer: queue-level reference model compared every cycle,
// plus directed scenarios with hand-computed expectations.
module tb_output_buffer;

  localparam int unsigned DW    = 16;
  localparam int unsigned WW    = 64;
  localparam int unsigned BEATS = 4;
  localparam int unsigned DEPTH = 8;
  localparam int unsigned CW    = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          wr_req;
  logic [WW-1:0] wr_data;
  logic          ready;
  logic          outbuf_cntl_full;
  logic          outbuf_cntl_idle;
  logic [CW-1:0] outbuf_cntl_count;
  logic          outbuf_tx_valid;
  logic [DW-1:0] outbuf_tx_data;
  logic          outbuf_tx_last;
`ifdef OUTBUF_OVERFLOW_FLAG_EN
  logic          outbuf_cntl_ovf;
`endif

  output_buffer dut (
    .clk                 (clk),
    .rst                 (rst),
    .cntl_outbuf_wr_req  (wr_req),
    .cntl_outbuf_wr_data (wr_data),
    .outbuf_cntl_full    (outbuf_cntl_full),
    .outbuf_cntl_idle    (outbuf_cntl_idle),
    .outbuf_cntl_count   (outbuf_cntl_count),
    .outbuf_tx_valid     (outbuf_tx_valid),
    .outbuf_tx_data      (outbuf_tx_data),
    .outbuf_tx_last      (outbuf_tx_last),
`ifdef OUTBUF_OVERFLOW_FLAG_EN
    .outbuf_cntl_ovf     (outbuf_cntl_ovf),
`endif
    .tx_outbuf_ready     (ready)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [DW-1:0] d;
    logic          l;
    int            c;
  } beat_t;

  // Reference model: a word queue plus the word currently on the bus.
  logic [WW-1:0] q[$];
  beat_t         m_beats[$];
  int            m_wcyc[$];
  bit            m_pending;
  bit            m_showing;
  int            m_beat;
  logic [WW-1:0] m_word;
  logic [WW-1:0] m_pend_word;
  bit            m_ovf;
  int            cyc;
  int            n_chk;
  int            n_pass;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
  endtask

  always @(posedge clk) begin : model
    int          sz;
    bit          acc;
    bit          take;
    beat_t       b;
    logic [6:0]  exp_st;
    logic [6:0]  act_st;
    cyc++;
    if (rst) begin
      q.delete();
      m_pending = 0;
      m_showing = 0;
      m_beat    = 0;
      m_ovf     = 0;
    end else begin
      sz   = q.size();
      acc  = wr_req && (sz < int'(DEPTH));
      take = 0;
      if (m_pending) begin
        m_word    = m_pend_word;
        m_showing = 1;
        m_beat    = 0;
        m_pending = 0;
      end else if (m_showing) begin
        if (ready) begin
          b.d = m_word[m_beat*DW +: DW];
          b.l = (m_beat == int'(BEATS) - 1);
          b.c = cyc;
          m_beats.push_back(b);
          if (m_beat == int'(BEATS) - 1) begin
            m_showing = 0;
            take = (sz > 0);
          end else begin
            m_beat++;
          end
        end
      end else begin
        take = (sz > 0);
      end
      if (take) begin
        m_pend_word = q.pop_front();
        m_pending   = 1;
      end
      if (acc) begin
        q.push_back(wr_data);
        m_wcyc.push_back(cyc);
      end else if (wr_req) begin
        m_ovf = 1;
      end
    end
    #1;
    exp_st = {q.size() == DEPTH, (q.size() == 0) && !m_pending && !m_showing,
              CW'(q.size()), m_showing};
    act_st = {outbuf_cntl_full, outbuf_cntl_idle, outbuf_cntl_count, outbuf_tx_valid};
    check("status{full,idle,count,valid}", 64'(act_st), 64'(exp_st));
    if (m_showing)
      check("beat{data,last}", 64'({outbuf_tx_data, outbuf_tx_last}),
            64'({m_word[m_beat*DW +: DW], m_beat == int'(BEATS) - 1}));
`ifdef OUTBUF_OVERFLOW_FLAG_EN
    check("ovf", 64'(outbuf_cntl_ovf), 64'(m_ovf));
`endif
  end

  task automatic push(input logic [WW-1:0] d);
    wr_req  = 1'b1;
    wr_data = d;
    @(negedge clk);
    wr_req  = 1'b0;
  endtask

  task automatic wait_valid(input string name);
    int i;
    i = 0;
    while (!outbuf_tx_valid && i < 40) begin
      @(negedge clk);
      i++;
    end
    check(name, 64'(outbuf_tx_valid), 64'(1));
  endtask

  task automatic wait_idle(input string name);
    int i;
    i = 0;
    while (!outbuf_cntl_idle && i < 300) begin
      @(negedge clk);
      i++;
    end
    check(name, 64'(outbuf_cntl_idle), 64'(1));
  endtask

  // Reassemble one word from four logged beats (LSB beat first).
  task automatic check_word(input string name, input int base, input logic [WW-1:0] exp);
    logic [WW-1:0]    w;
    logic [BEATS-1:0] l;
    w = '0;
    l = '0;
    for (int k = 0; k < int'(BEATS); k++) begin
      if (base + k < m_beats.size()) begin
        w[k*DW +: DW] = m_beats[base+k].d;
        l[k]          = m_beats[base+k].l;
      end
    end
    check(name, 64'(w), 64'(exp));
    check({name, "_last"}, 64'(l), 64'(4'b1000));
  endtask

  initial begin
    logic [WW-1:0] exp_w[$];
    int            pushed;
    int            guard;
    rst     = 1'b1;
    wr_req  = 1'b0;
    wr_data = '0;
    ready   = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_count", 64'(outbuf_cntl_count), 64'(0));
    check("rst_idle",  64'(outbuf_cntl_idle),  64'(1));
    check("rst_full",  64'(outbuf_cntl_full),  64'(0));
    check("rst_tx",    64'({outbuf_tx_valid, outbuf_tx_data, outbuf_tx_last}), 64'(0));
    rst = 1'b0;

    // Single word, ready held high.
    m_beats.delete();
    m_wcyc.delete();
    push(64'h0123_4567_89AB_CDEF);
    repeat (8) @(negedge clk);
    check("t1_nbeats", 64'(m_beats.size()), 64'(4));
    check_word("t1_word", 0, 64'h0123_4567_89AB_CDEF);
    check("t1_beat0", 64'(m_beats[0].d), 64'(16'hCDEF));
    check("t1_beat3", 64'(m_beats[3].d), 64'(16'h0123));
    check("t1_latency", 64'(m_beats[0].c - m_wcyc[0]), 64'(3));
    check("t1_idle", 64'(outbuf_cntl_idle), 64'(1));

    // Backpressure on beat 1.
    m_beats.delete();
    ready = 1'b0;
    push(64'h0123_4567_89AB_CDEF);
    wait_valid("t2_valid_seen");
    ready = 1'b1;
    @(negedge clk);
    ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check("t2_stall", 64'({outbuf_tx_valid, outbuf_tx_data}), 64'({1'b1, 16'h89AB}));
      @(negedge clk);
    end
    ready = 1'b1;
    wait_idle("t2_idle");
    check("t2_nbeats", 64'(m_beats.size()), 64'(4));
    check_word("t2_word", 0, 64'h0123_4567_89AB_CDEF);

    // Fill with ready low; one word is pulled into the serializer, so the 10th write is dropped.
    m_beats.delete();
    ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (i == 9) begin
        check("t3_count_sat", 64'(outbuf_cntl_count), 64'(8));
        check("t3_full", 64'(outbuf_cntl_full), 64'(1));
`ifdef OUTBUF_OVERFLOW_FLAG_EN
        check("t3_ovf_before", 64'(outbuf_cntl_ovf), 64'(0));
`endif
      end
      wr_req  = 1'b1;
      wr_data = 64'hA5A5_0000_0000_0000 | 64'(i);
      @(negedge clk);
    end
    wr_req = 1'b0;
    check("t3_count_after_drop", 64'(outbuf_cntl_count), 64'(8));
`ifdef OUTBUF_OVERFLOW_FLAG_EN
    check("t3_ovf_after", 64'(outbuf_cntl_ovf), 64'(1));
`endif
    ready = 1'b1;
    wait_idle("t3_idle");
    check("t3_nbeats", 64'(m_beats.size()), 64'(36));
    for (int i = 0; i < 8; i++) check_word("t3_word", 4*i, 64'hA5A5_0000_0000_0000 | 64'(i));
    check_word("t3_word8", 32, 64'hA5A5_0000_0000_0008);

    // Streaming eight words with ready high.
    m_beats.delete();
    for (int i = 0; i < 8; i++) push(64'h1111_2222_3333_0000 | 64'(i));
    wait_idle("t4_idle");
    check("t4_nbeats", 64'(m_beats.size()), 64'(32));
    for (int i = 0; i < 8; i++) check_word("t4_word", 4*i, 64'h1111_2222_3333_0000 | 64'(i));
    for (int k = 0; k < 7; k++)
      check("t4_period", 64'(m_beats[4*(k+1)].c - m_beats[4*k].c), 64'(5));
    check("t4_count", 64'(outbuf_cntl_count), 64'(0));

    // Coincident write and read at count 3.
    m_beats.delete();
    ready = 1'b0;
    for (int i = 0; i < 4; i++) push(64'hC0C0_0000_0000_0000 | 64'(i));
    check("t5_count_pre", 64'(outbuf_cntl_count), 64'(3));
    wait_valid("t5_valid");
    ready = 1'b1;
    repeat (3) @(negedge clk);
    check("t5_on_last", 64'(outbuf_tx_last), 64'(1));
    wr_req  = 1'b1;
    wr_data = 64'hDEAD_BEEF_F00D_CAFE;
    @(negedge clk);
    wr_req = 1'b0;
    check("t5_count_coincident", 64'(outbuf_cntl_count), 64'(3));
    wait_idle("t5_idle");
    check("t5_nbeats", 64'(m_beats.size()), 64'(20));
    for (int i = 0; i < 4; i++) check_word("t5_word", 4*i, 64'hC0C0_0000_0000_0000 | 64'(i));
    check_word("t5_wordx", 16, 64'hDEAD_BEEF_F00D_CAFE);

    // Twenty random words with random ready, writing only when not full.
    m_beats.delete();
    pushed = 0;
    guard  = 0;
    while (pushed < 20 && guard < 2000) begin
      ready = 1'($urandom_range(0, 1));
      if (!outbuf_cntl_full) begin
        wr_req  = 1'b1;
        wr_data = {$urandom(), $urandom()};
        exp_w.push_back(wr_data);
        pushed++;
      end else begin
        wr_req = 1'b0;
      end
      @(negedge clk);
      guard++;
    end
    wr_req = 1'b0;
    ready  = 1'b1;
    check("t6_pushed", 64'(pushed), 64'(20));
    wait_idle("t6_idle");
    check("t6_nbeats", 64'(m_beats.size()), 64'(80));
    for (int i = 0; i < 20; i++) check_word("t6_word", 4*i, exp_w[i]);

    // Reset in the middle of a word.
    m_beats.delete();
    ready = 1'b0;
    push(64'h7777_6666_5555_4444);
    push(64'h8888_9999_AAAA_BBBB);
    wait_valid("t7_valid");
    ready = 1'b1;
    repeat (2) @(negedge clk);
    ready = 1'b0;
    check("t7_pre_beats", 64'(m_beats.size()), 64'(2));
    rst = 1'b1;
    @(negedge clk);
    check("t7_rst_state", 64'({outbuf_tx_valid, outbuf_cntl_count, outbuf_cntl_idle, outbuf_cntl_full}),
          64'({1'b0, 4'd0, 1'b1, 1'b0}));
`ifdef OUTBUF_OVERFLOW_FLAG_EN
    check("t7_ovf_cleared", 64'(outbuf_cntl_ovf), 64'(0));
`endif
    rst = 1'b0;
    m_beats.delete();
    ready = 1'b1;
    repeat (12) @(negedge clk);
    check("t7_no_stale", 64'(m_beats.size()), 64'(0));
    check("t7_idle", 64'(outbuf_cntl_idle), 64'(1));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
